pc_stack_unit: RTL

//  Parametrised program counter with integrated hardware return stack for the iCEPIC core.

---
 rtl/pc_stack_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with an integrated circular return stack and sticky overflow/underflow flags.
// Latency: every op is applied at the sampling edge and shows on pc_out/stack_level_out one cycle later.
// Backpressure: none; the decoder stalls the PC with HOLD (or the reserved op 3'b111).
// Optional feature macro: PC_STACK_TRAP_EN (stack faults redirect the PC to TRAP_VEC).
module pc_stack_unit #(
  parameter int              PC_W        = 12,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = 'h000,
  parameter logic [PC_W-1:0] TRAP_VEC    = 'h004
) (
  input  logic                               clk_in,
  input  logic                               reset_in,
  input  logic [2:0]                         op_in,
  input  logic [PC_W-1:0]                    jump_addr_in,
  input  logic [PC_W-1:0]                    pcl_mod_in,
  input  logic                               flag_clr_in,
  output logic [PC_W-1:0]                    pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level_out,
  output logic                               stack_ovf_out,
  output logic                               stack_unf_out,
  output logic                               trap_out
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JUMP = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_PCL  = 3'b101;
  localparam logic [2:0] OP_SKIP = 3'b110;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             trap_q, trap_d;
  logic             push_en;
  logic             ovf_set, unf_set;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  logic             full, empty;
  logic [PC_W-1:0]  pc_inc, pc_skip, top_val;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  assign full    = (lvl_q == LVL_W'(STACK_DEPTH));
  assign empty   = (lvl_q == '0);
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_skip = pc_q + PC_W'(2);
  // Pointer arithmetic is modulo the stack depth, which need not be a power of two.
  assign ptr_inc = (ptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : ptr_q - PTR_W'(1);
  // Combinational read so a RET right after a CALL sees the freshly written entry.
  assign top_val = stack_q[ptr_dec];

  // Next-state decode of the PC operation, stack pointer/level and fault detection.
  always_comb begin
    pc_d    = pc_q;
    lvl_d   = lvl_q;
    ptr_d   = ptr_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    trap_d  = 1'b0;
    case (op_in)
      OP_INC:  pc_d = pc_inc;
      OP_JUMP: pc_d = jump_addr_in;
      OP_PCL:  pc_d = pcl_mod_in;
      OP_SKIP: pc_d = pc_skip;
      OP_CALL: begin
        ovf_set = full;
        if (TRAP_EN && full) begin
          pc_d   = TRAP_VEC;
          trap_d = 1'b1;
        end else begin
          // Without trapping, a full stack silently overwrites its oldest entry.
          push_en = 1'b1;
          ptr_d   = ptr_inc;
          lvl_d   = full ? lvl_q : lvl_q + LVL_W'(1);
          pc_d    = jump_addr_in;
        end
      end
      OP_RET: begin
        unf_set = empty;
        if (TRAP_EN && empty) begin
          pc_d   = TRAP_VEC;
          trap_d = 1'b1;
        end else begin
          // Without trapping, an empty pop returns stale data and still moves the pointer.
          pc_d  = top_val;
          ptr_d = ptr_dec;
          lvl_d = empty ? lvl_q : lvl_q - LVL_W'(1);
        end
      end
      OP_HOLD: pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
    // A new fault wins over a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~flag_clr_in);
    unf_d = unf_set | (unf_q & ~flag_clr_in);
  end

  // Architectural state register with asynchronous reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pc_q   <= RESET_VEC;
      lvl_q  <= '0;
      ptr_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      lvl_q  <= lvl_d;
      ptr_q  <= ptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      trap_q <= trap_d;
    end
  end

  // Return-address storage; contents are don't-care after reset so it has none.
  always_ff @(posedge clk_in) begin
    if (push_en) stack_q[ptr_q] <= pc_inc;
  end

  assign pc_out          = pc_q;
  assign stack_level_out = lvl_q;
  assign stack_ovf_out   = ovf_q;
  assign stack_unf_out   = unf_q;
  assign trap_out        = TRAP_EN ? trap_q : 1'b0;

endmodule
